// File: rtl/matrix_mult_sequencer.sv
// Control sequencer for C = A * B with B stored transposed: walks every (row, col)
// pair, tracks each issue through read and dot-product latency, and strobes row writes.
module matrix_mult_sequencer #(
  parameter int BATCH_SIZE          = 8,
  parameter int LOG_BATCH_SIZE      = 3,
  parameter int OUTPUT_FEATURES     = 8,
  parameter int LOG_OUTPUT_FEATURES = 3,
  parameter int RD_LATENCY          = 1,
  parameter int DP_LATENCY          = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           hold,
  output logic                           busy,
  output logic                           done,
  output logic                           rdEn,
  output logic [LOG_BATCH_SIZE-1:0]      inputAddr,
  output logic [LOG_OUTPUT_FEATURES-1:0] weightAddr,
  output logic                           dpEn,
  output logic                           colWrEn,
  output logic [LOG_OUTPUT_FEATURES-1:0] colSel,
  output logic [LOG_BATCH_SIZE-1:0]      outputAddr,
  output logic                           outputWrEn
);

  localparam int PIPE_DEPTH = RD_LATENCY + DP_LATENCY;
  localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
  localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [LOG_BATCH_SIZE-1:0]        row_q, row_d;
  logic [LOG_OUTPUT_FEATURES-1:0]   col_q, col_d;
  logic                             wrPend_q, wrPend_d;
  logic [LOG_BATCH_SIZE-1:0]        outAddr_q, outAddr_d;

  // Tag pipeline: entry i holds the issue made i+1 active cycles ago.
  logic [PIPE_DEPTH-1:0]            tagValid_q;
  logic [LOG_BATCH_SIZE-1:0]        tagRow_q [PIPE_DEPTH];
  logic [LOG_OUTPUT_FEATURES-1:0]   tagCol_q [PIPE_DEPTH];

  logic issue;
  logic pipeEmpty;
  logic lastColCapture;

  assign pipeEmpty      = (tagValid_q == '0);
  assign lastColCapture = tagValid_q[PIPE_DEPTH-1] && (tagCol_q[PIPE_DEPTH-1] == LAST_COL);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !hold) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + LOG_BATCH_SIZE'(1);
          end else begin
            col_d = col_q + LOG_OUTPUT_FEATURES'(1);
          end
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // The final row write is the only one that can coincide with an empty pipeline.
        if (!hold && pipeEmpty && wrPend_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrPend_d  = wrPend_q;
    outAddr_d = outAddr_q;
    if (!hold) begin
      wrPend_d = lastColCapture;
      if (lastColCapture) begin
        outAddr_d = tagRow_q[PIPE_DEPTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wrPend_q  <= 1'b0;
      outAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wrPend_q  <= wrPend_d;
      outAddr_q <= outAddr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tagValid_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        tagRow_q[i] <= '0;
        tagCol_q[i] <= '0;
      end
    end else if (!hold) begin
      tagValid_q  <= {tagValid_q[PIPE_DEPTH-2:0], issue};
      tagRow_q[0] <= row_q;
      tagCol_q[0] <= col_q;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tagRow_q[i] <= tagRow_q[i-1];
        tagCol_q[i] <= tagCol_q[i-1];
      end
    end
  end

  // Strobes are masked by hold so attached units see nothing while frozen.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE) && !hold;
  assign rdEn       = issue;
  assign inputAddr  = row_q;
  assign weightAddr = col_q;
  assign dpEn       = tagValid_q[RD_LATENCY-1] && !hold;
  assign colWrEn    = tagValid_q[PIPE_DEPTH-1] && !hold;
  assign colSel     = tagCol_q[PIPE_DEPTH-1];
  assign outputAddr = outAddr_q;
  assign outputWrEn = wrPend_q && !hold;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Scoreboard bench for matrix_mult_sequencer: a default-size instance and a 1x1 instance
// with longer latencies, driven from start/hold plans and checked against an event model.
module tb_matrix_mult_sequencer;

  localparam int PLAN_LEN = 8192;

  typedef struct {
    int cyc;
    int a;
    int b;
  } evt_t;

  logic clk = 1'b0;
  int   cyc = 0;

  logic rstA = 1'b0, startA = 1'b0, holdA = 1'b0;
  logic busyA, doneA, rdEnA, dpEnA, colWrEnA, outputWrEnA;
  logic [2:0] inputAddrA, weightAddrA, colSelA, outputAddrA;

  logic rstB = 1'b0, startB = 1'b0, holdB = 1'b0;
  logic busyB, doneB, rdEnB, dpEnB, colWrEnB, outputWrEnB;
  logic [0:0] inputAddrB, weightAddrB, colSelB, outputAddrB;

  // Queue index is dut*5 + kind, kinds being rdEn, dpEn, colWrEn, outputWrEn, done.
  evt_t  expQ [10][$];
  evt_t  busyWin [2][$];
  bit    holdPlan [2][PLAN_LEN];
  bit    startPlan [2][PLAN_LEN];
  int    mP [2]  = '{8, 1};
  int    oP [2]  = '{8, 1};
  int    rdP [2] = '{1, 2};
  int    dpP [2] = '{2, 3};
  string kindName [5] = '{"rdEn", "dpEn", "colWrEn", "outputWrEn", "done"};

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  matrix_mult_sequencer dutA (
    .clk(clk), .rst(rstA), .start(startA), .hold(holdA),
    .busy(busyA), .done(doneA), .rdEn(rdEnA),
    .inputAddr(inputAddrA), .weightAddr(weightAddrA),
    .dpEn(dpEnA), .colWrEn(colWrEnA), .colSel(colSelA),
    .outputAddr(outputAddrA), .outputWrEn(outputWrEnA)
  );

  matrix_mult_sequencer #(
    .BATCH_SIZE(1), .LOG_BATCH_SIZE(1), .OUTPUT_FEATURES(1), .LOG_OUTPUT_FEATURES(1),
    .RD_LATENCY(2), .DP_LATENCY(3)
  ) dutB (
    .clk(clk), .rst(rstB), .start(startB), .hold(holdB),
    .busy(busyB), .done(doneB), .rdEn(rdEnB),
    .inputAddr(inputAddrB), .weightAddr(weightAddrB),
    .dpEn(dpEnB), .colWrEn(colWrEnB), .colSel(colSelB),
    .outputAddr(outputAddrB), .outputWrEn(outputWrEnB)
  );

  // Nominal (hold-free) job cycle n lands on the n-th unheld cycle counted from s.
  function automatic int absOf(input int d, input int s, input int n);
    int c;
    int cnt;
    c = s;
    cnt = 0;
    while (c < PLAN_LEN - 1) begin
      if (!holdPlan[d][c]) begin
        cnt++;
        if (cnt == n) return c;
      end
      c++;
    end
    return c;
  endfunction

  task automatic pushEvt(input int q, input int c, input int a, input int b);
    evt_t e;
    e.cyc = c;
    e.a = a;
    e.b = b;
    expQ[q].push_back(e);
  endtask

  task automatic scheduleJob(input int d, input int x, output int startAbs, output int doneAbs);
    int c, m, o, lat;
    evt_t w;
    c = x;
    while (!(startPlan[d][c] && !holdPlan[d][c]) && c < PLAN_LEN - 400) c++;
    startAbs = c + 1;
    m = mP[d];
    o = oP[d];
    lat = rdP[d] + dpP[d];
    for (int k = 0; k < m * o; k++) begin
      pushEvt(d * 5 + 0, absOf(d, startAbs, 1 + k), k / o, k % o);
      pushEvt(d * 5 + 1, absOf(d, startAbs, 1 + k + rdP[d]), 0, 0);
      pushEvt(d * 5 + 2, absOf(d, startAbs, 1 + k + lat), k % o, 0);
    end
    for (int r = 0; r < m; r++) begin
      pushEvt(d * 5 + 3, absOf(d, startAbs, (r + 1) * o + lat + 1), r, 0);
    end
    doneAbs = absOf(d, startAbs, m * o + lat + 2);
    pushEvt(d * 5 + 4, doneAbs, 0, 0);
    w.cyc = 0;
    w.a = startAbs;
    w.b = doneAbs;
    busyWin[d].push_back(w);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    holdA  = holdPlan[0][cyc];
    startA = startPlan[0][cyc];
    holdB  = holdPlan[1][cyc];
    startB = startPlan[1][cyc];
  endtask

  task automatic runUntil(input int target);
    while (cyc < target) applyStimulus();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic checkAllZero(input int d, input string tag);
    if (d == 0) begin
      checkOutput({tag, " busy"}, int'(busyA), 0);
      checkOutput({tag, " done"}, int'(doneA), 0);
      checkOutput({tag, " rdEn"}, int'(rdEnA), 0);
      checkOutput({tag, " dpEn"}, int'(dpEnA), 0);
      checkOutput({tag, " colWrEn"}, int'(colWrEnA), 0);
      checkOutput({tag, " outputWrEn"}, int'(outputWrEnA), 0);
      checkOutput({tag, " inputAddr"}, int'(inputAddrA), 0);
      checkOutput({tag, " weightAddr"}, int'(weightAddrA), 0);
      checkOutput({tag, " colSel"}, int'(colSelA), 0);
      checkOutput({tag, " outputAddr"}, int'(outputAddrA), 0);
    end else begin
      checkOutput({tag, " busy"}, int'(busyB), 0);
      checkOutput({tag, " done"}, int'(doneB), 0);
      checkOutput({tag, " rdEn"}, int'(rdEnB), 0);
      checkOutput({tag, " colWrEn"}, int'(colWrEnB), 0);
      checkOutput({tag, " outputAddr"}, int'(outputAddrB), 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a strobe appears and flags anything overdue.
  always @(negedge clk) begin
    logic s [5];
    int   a [5];
    int   b [5];
    logic bz;
    bit   expBusy;
    evt_t e;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        s[0] = rdEnA; a[0] = int'(inputAddrA); b[0] = int'(weightAddrA);
        s[1] = dpEnA; a[1] = 0; b[1] = 0;
        s[2] = colWrEnA; a[2] = int'(colSelA); b[2] = 0;
        s[3] = outputWrEnA; a[3] = int'(outputAddrA); b[3] = 0;
        s[4] = doneA; a[4] = 0; b[4] = 0;
        bz = busyA;
      end else begin
        s[0] = rdEnB; a[0] = int'(inputAddrB); b[0] = int'(weightAddrB);
        s[1] = dpEnB; a[1] = 0; b[1] = 0;
        s[2] = colWrEnB; a[2] = int'(colSelB); b[2] = 0;
        s[3] = outputWrEnB; a[3] = int'(outputAddrB); b[3] = 0;
        s[4] = doneB; a[4] = 0; b[4] = 0;
        bz = busyB;
      end
      for (int k = 0; k < 5; k++) begin
        while (expQ[d * 5 + k].size() > 0 && expQ[d * 5 + k][0].cyc < cyc) begin
          e = expQ[d * 5 + k].pop_front();
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL dut%0d %s missing: no strobe observed, required at cycle %0d (a=%0d b=%0d)",
                   d, kindName[k], e.cyc, e.a, e.b);
        end
        if (s[k] === 1'b1) begin
          testsRun++;
          if (expQ[d * 5 + k].size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL dut%0d %s unexpected at cycle %0d (a=%0d b=%0d), required none",
                     d, kindName[k], cyc, a[k], b[k]);
          end else begin
            e = expQ[d * 5 + k].pop_front();
            if (e.cyc != cyc || e.a != a[k] || e.b != b[k]) begin
              testsFailed++;
              $display("[TB] FAIL dut%0d %s: got cycle %0d a=%0d b=%0d, expected cycle %0d a=%0d b=%0d",
                       d, kindName[k], cyc, a[k], b[k], e.cyc, e.a, e.b);
            end
          end
        end
      end
      expBusy = 1'b0;
      foreach (busyWin[d][i]) begin
        if (cyc >= busyWin[d][i].a && cyc <= busyWin[d][i].b) expBusy = 1'b1;
      end
      testsRun++;
      if (bz !== expBusy) begin
        testsFailed++;
        $display("[TB] FAIL dut%0d busy at cycle %0d: got %b, expected %b", d, cyc, bz, expBusy);
      end
    end
  end

  initial begin
    int x, sAbs, dAbs, dA, dB, lastA, lastB, prevDone;

    repeat (2) applyStimulus();
    #1;
    checkAllZero(0, "resetA");
    checkAllZero(1, "resetB");
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus();

    // Plain job on both instances.
    x = cyc + 2;
    startPlan[0][x] = 1'b1;
    startPlan[1][x] = 1'b1;
    scheduleJob(0, x, sAbs, dA);
    scheduleJob(1, x, sAbs, dB);
    runUntil(dA + 2);

    // Hold in job cycles 10-12 plus a stray start in job cycle 30.
    x = cyc + 2;
    startPlan[0][x] = 1'b1;
    for (int c = x + 10; c <= x + 12; c++) holdPlan[0][c] = 1'b1;
    startPlan[0][x + 30] = 1'b1;
    scheduleJob(0, x, sAbs, dA);
    checkOutput("held done lands in job cycle 72", dA - sAbs + 1, 72);
    runUntil(dA + 2);

    // Reset in job cycle 40 aborts the job, then a fresh job runs cleanly.
    x = cyc + 2;
    startPlan[0][x] = 1'b1;
    scheduleJob(0, x, sAbs, dA);
    runUntil(sAbs + 39);
    rstA = 1'b0;
    for (int k = 0; k < 5; k++) expQ[k].delete();
    busyWin[0].delete();
    #1;
    checkAllZero(0, "midJobReset");
    repeat (3) applyStimulus();
    rstA = 1'b1;
    x = cyc + 2;
    startPlan[0][x] = 1'b1;
    scheduleJob(0, x, sAbs, dA);
    runUntil(dA + 2);

    // start with hold in IDLE must wait for hold to drop.
    x = cyc + 2;
    for (int c = x; c <= x + 4; c++) startPlan[0][c] = 1'b1;
    for (int c = x; c <= x + 3; c++) holdPlan[0][c] = 1'b1;
    startPlan[1][x] = 1'b1;
    startPlan[1][x + 1] = 1'b1;
    holdPlan[1][x] = 1'b1;
    scheduleJob(0, x, sAbs, dA);
    checkOutput("hold-gated launch A", sAbs, x + 5);
    scheduleJob(1, x, sAbs, dB);
    checkOutput("hold-gated launch B", sAbs, x + 2);
    runUntil(((dA > dB) ? dA : dB) + 2);

    // Random holds, stray starts and chained jobs, some starting the cycle after done.
    for (int d = 0; d < 2; d++) begin
      prevDone = cyc + 2;
      for (int j = 0; j < ((d == 0) ? 4 : 8); j++) begin
        x = prevDone + 1 + ((j % 2 == 1) ? 0 : int'($urandom_range(0, 3)));
        for (int c = x + 1; c <= x + 160; c++) holdPlan[d][c] = ($urandom_range(0, 7) == 0);
        holdPlan[d][x] = 1'b0;
        startPlan[d][x] = 1'b1;
        scheduleJob(d, x, sAbs, dAbs);
        startPlan[d][$urandom_range(sAbs, dAbs)] = 1'b1;
        prevDone = dAbs;
      end
      if (d == 0) lastA = prevDone;
      else lastB = prevDone;
    end
    runUntil(((lastA > lastB) ? lastA : lastB) + 3);

    for (int q = 0; q < 10; q++) begin
      checkOutput({"leftover ", kindName[q % 5], (q < 5) ? " dutA" : " dutB"}, expQ[q].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
